// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Single-port 32-bit data-memory responder with valid/ready
//             request and response channels, fixed wait latency, byte-lane
//             writes and misaligned/out-of-range error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          C_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  C_LAT   = 4'(LATENCY);
  localparam logic [31:0] C_DEPTH = 32'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  // Request fields held while the access waits out its latency
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;

  logic [31:0]     mem_q [DEPTH];

  // Fields of the access that completes on this edge: with zero latency the
  // request completes on its own acceptance edge, so take the live inputs
  logic            accept;
  logic            go_resp;
  logic            sel_we;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_be;
  logic            sel_err;
  logic [C_AW-1:0] sel_idx;

  // Select the completing request and decide whether this edge enters RESP
  always_comb begin
    accept    = (state_q == ST_IDLE) && req_valid;
    sel_we    = we_q;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    sel_be    = be_q;
    if (state_q == ST_IDLE) begin
      sel_we    = req_we;
      sel_addr  = req_addr;
      sel_wdata = req_wdata;
      sel_be    = req_be;
    end
    go_resp = reset &&
              ((accept && (C_LAT == 4'd0)) ||
               ((state_q == ST_BUSY) && (cnt_q == 4'd1)));
    sel_err = (sel_addr[1:0] != 2'b00) ||
              ({2'b00, sel_addr[31:2]} >= C_DEPTH);
    sel_idx = sel_addr[C_AW+1:2];
  end

  // Storage: commits enabled lanes of a good write on RESP entry; never reset
  always_ff @(posedge clk) begin
    if (go_resp && sel_we && !sel_err) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_be[i]) begin
          mem_q[sel_idx][8*i +: 8] <= sel_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= C_LAT;
            req_ready_q <= 1'b0;
            if (C_LAT == 4'd0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd1) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            cnt_q       <= 4'd0;
          end else begin
            cnt_q       <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
      // Response payload is captured once and held for the whole RESP phase
      if (go_resp) begin
        rsp_err_q   <= sel_err;
        rsp_rdata_q <= (!sel_err && !sel_we) ? mem_q[sel_idx] : 32'd0;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Bench for dmem_responder; two instances (latency 2 and 0)
//             checked every cycle against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT0  = 2;
  localparam int LAT1  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;   // rising edges seen so far

  always @(posedge clk) ecnt++;

  task automatic check(input string name, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, k, $time, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // ---------------- transaction-level model ----------------
  // mode: 0 = can accept, 1 = waiting for deadline edge, 2 = responding
  int          m_mode    [2];
  int          m_due     [2];
  logic        m_we      [2];
  logic [31:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic [3:0]  m_be      [2];
  logic [31:0] m_rdata   [2];
  logic        m_err     [2];
  logic        m_rknown  [2];
  logic        m_live    [2];
  logic        m_postrst [2];
  logic [31:0] m_mem     [2][DEPTH];
  logic        m_known   [2][DEPTH];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_due[k] = 0; m_live[k] = 1'b0; m_postrst[k] = 1'b0;
      m_we[k] = 1'b0; m_addr[k] = 32'd0; m_wdata[k] = 32'd0; m_be[k] = 4'd0;
      m_rdata[k] = 32'd0; m_err[k] = 1'b0; m_rknown[k] = 1'b0;
      for (int w = 0; w < DEPTH; w++) begin
        m_mem[k][w] = 32'd0; m_known[k][w] = 1'b0;
      end
    end
  end

  task automatic enter_resp(input int k);
    int   idx;
    logic err;
    err = (m_addr[k][1:0] != 2'b00) || ({2'b00, m_addr[k][31:2]} >= 32'(DEPTH));
    m_mode[k]    = 2;
    m_postrst[k] = 1'b0;
    m_err[k]     = err;
    m_rdata[k]   = 32'd0;
    m_rknown[k]  = 1'b1;
    if (!err) begin
      idx = int'(m_addr[k][31:2]);
      if (m_we[k]) begin
        for (int i = 0; i < 4; i++)
          if (m_be[k][i]) m_mem[k][idx][8*i +: 8] = m_wdata[k][8*i +: 8];
        if (m_be[k] == 4'hF) m_known[k][idx] = 1'b1;
      end else begin
        m_rdata[k]  = m_mem[k][idx];
        m_rknown[k] = m_known[k][idx];
      end
    end
  endtask

  // Advance the model across the coming rising edge
  task automatic model_step(input int k);
    int nxt;
    nxt = ecnt + 1;
    if (!reset[k]) begin
      m_mode[k] = 0; m_live[k] = 1'b1; m_postrst[k] = 1'b1;
      m_rdata[k] = 32'd0; m_err[k] = 1'b0; m_rknown[k] = 1'b1;
    end else begin
      case (m_mode[k])
        0: if (req_valid[k]) begin
             m_we[k] = req_we[k]; m_addr[k] = req_addr[k];
             m_wdata[k] = req_wdata[k]; m_be[k] = req_be[k];
             if (lat_of(k) == 0) enter_resp(k);
             else begin m_mode[k] = 1; m_due[k] = nxt + lat_of(k); end
           end
        1: if (nxt == m_due[k]) enter_resp(k);
        2: if (rsp_ready[k]) m_mode[k] = 0;
        default: m_mode[k] = 0;
      endcase
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_live[k]) begin
        check("req_ready", k, 32'(req_ready[k]), 32'(m_mode[k] == 0));
        check("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_mode[k] == 2));
        if (m_mode[k] == 2 || m_postrst[k]) begin
          check("rsp_err", k, 32'(rsp_err[k]), 32'(m_err[k]));
          if (m_rknown[k]) check("rsp_rdata", k, rsp_rdata[k], m_rdata[k]);
        end
      end
      model_step(k);
    end
  end

  // ---------------- directed helpers ----------------
  // Called #1 after a rising edge; returns latency in edges and accept edge
  task automatic txn(input int k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     output logic [31:0] rdata, output logic err,
                     output int lat, output int acc);
    int n;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_wdata[k] = wdata; req_be[k] = be;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_wait", k, 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    acc = ecnt;
    req_valid[k] = 1'b0;
    n = 1;
    while (!rsp_valid[k] && n < 50) begin @(posedge clk); #1; n++; end
    lat   = n - 1;
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = h[0];
      req_addr[k]  = 32'h0000_0010;
      req_we[k]    = 1'b1;
      @(posedge clk); #1;
      check("bp_req_ready", k, 32'(req_ready[k]), 32'd0);
      check("bp_rsp_valid", k, 32'(rsp_valid[k]), 32'd1);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, acc, acc_prev;
    logic [31:0] a;
    int          r;

    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; req_be[k] = 4'd0;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      check("rst_req_ready", k, 32'(req_ready[k]), 32'd1);
      check("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
      check("rst_rdata",     k, rsp_rdata[k],      32'd0);
      check("rst_err",       k, 32'(rsp_err[k]),   32'd0);
    end

    // Fill both memories so every later read has a known value
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < DEPTH; w++)
        txn(k, 1'b1, 32'(w * 4), $urandom(), 4'hF, 0, rd, er, lat, acc);

    // Latency-2 instance: full write, partial write, be=0, errors
    txn(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, acc);
    check("wr_latency", 0, 32'(lat), 32'd2);
    check("wr_err",     0, 32'(er),  32'd0);
    check("wr_rdata",   0, rd,       32'd0);
    txn(0, 1'b0, 32'h08, 32'd0, 4'h0, 0, rd, er, lat, acc);
    check("rd_full",    0, rd, 32'hDEADBEEF);
    check("rd_latency", 0, 32'(lat), 32'd2);
    txn(0, 1'b1, 32'h08, 32'h11223344, 4'h5, 0, rd, er, lat, acc);
    txn(0, 1'b0, 32'h08, 32'd0, 4'h0, 0, rd, er, lat, acc);
    check("rd_partial", 0, rd, 32'hDE22BE44);
    txn(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, acc);
    check("be0_err",    0, 32'(er), 32'd0);
    txn(0, 1'b0, 32'h08, 32'd0, 4'hF, 0, rd, er, lat, acc);
    check("be0_noop",   0, rd, 32'hDE22BE44);
    txn(0, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, acc);
    txn(0, 1'b0, 32'h06, 32'd0, 4'hF, 0, rd, er, lat, acc);
    check("misal_err",   0, 32'(er), 32'd1);
    check("misal_rdata", 0, rd,      32'd0);
    txn(0, 1'b1, 32'h100, 32'h0, 4'hF, 0, rd, er, lat, acc);
    check("oor_wr_err",  0, 32'(er), 32'd1);
    txn(0, 1'b0, 32'h100, 32'd0, 4'hF, 0, rd, er, lat, acc);
    check("oor_err",     0, 32'(er), 32'd1);
    check("oor_rdata",   0, rd,      32'd0);
    txn(0, 1'b0, 32'h04, 32'd0, 4'hF, 0, rd, er, lat, acc);
    check("word4_kept",  0, rd, 32'hCAFEF00D);

    // Backpressure with ignored request pulses
    txn(0, 1'b0, 32'h08, 32'd0, 4'hF, 5, rd, er, lat, acc);
    check("bp_rdata", 0, rd, 32'hDE22BE44);

    // Reset one cycle after accepting a write aborts it
    txn(0, 1'b1, 32'h0C, 32'h0BADCAFE, 4'hF, 0, rd, er, lat, acc);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0C;
    req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
    @(posedge clk); #1;               // accepted here
    req_valid[0] = 1'b0;
    reset[0] = 1'b0;
    @(posedge clk); #1;               // reset sampled in BUSY
    reset[0] = 1'b1;
    check("abort_req_ready", 0, 32'(req_ready[0]), 32'd1);
    check("abort_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    txn(0, 1'b0, 32'h0C, 32'd0, 4'hF, 0, rd, er, lat, acc);
    check("abort_no_commit", 0, rd, 32'h0BADCAFE);

    // Latency-0 instance: back-to-back reads every two cycles
    txn(1, 1'b1, 32'h10, 32'hA5A55A5A, 4'hF, 0, rd, er, lat, acc);
    check("l0_wr_latency", 1, 32'(lat), 32'd0);
    acc_prev = acc;
    for (int i = 0; i < 4; i++) begin
      txn(1, 1'b0, 32'h10, 32'd0, 4'hF, 0, rd, er, lat, acc);
      check("l0_rdata",   1, rd, 32'hA5A55A5A);
      check("l0_latency", 1, 32'(lat), 32'd0);
      check("l0_spacing", 1, 32'(acc - acc_prev), 32'd2);
      acc_prev = acc;
    end

    // Randomized traffic on both instances, checked by the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = $urandom();
        else if (r == 1) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        else             a = {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
        reset[k]     = ($urandom_range(0, 199) != 0);
        req_valid[k] = $urandom_range(0, 1) == 1;
        req_we[k]    = $urandom_range(0, 1) == 1;
        req_addr[k]  = a;
        req_wdata[k] = $urandom();
        req_be[k]    = 4'($urandom_range(0, 15));
        rsp_ready[k] = ($urandom_range(0, 9) < 6);
      end
      @(posedge clk); #1;
    end

    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    end
    repeat (20) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
